aes256_iter_ctrl: RTL and testbench

Iterative AES-256 encryption controller that sequences a single shared `encryption_rounds` datapath over all 14 rounds instead of unrolling them. It owns the key register, the state register and the round counter, and drives the combinational `key_expansion`, `sub_bytes`, `shift_rows` and `add_round_key` units. It presents valid/ready handshakes for key load, plaintext in and ciphertext out. It replaces the fully unrolled encryptor wherever area matters more than throughput.

---
 rtl/aes256_iter_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_aes256_iter_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_iter_ctrl.sv
// Iterative AES-256 encryption controller.
// One round datapath is reused across all 14 rounds. The key schedule is
// expanded combinationally from the key register and is treated as a
// multicycle path: key_valid_o rises only after key_settle_p settle cycles.
module aes256_iter_ctrl #(
  parameter int key_settle_p = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         key_v_i,
  input  logic [255:0] key_i,
  output logic         key_ready_o,
  output logic         key_valid_o,
  input  logic         v_i,
  input  logic [127:0] plaintext_i,
  output logic         ready_o,
  output logic         v_o,
  output logic [127:0] ciphertext_o,
  input  logic         ready_i,
  output logic         busy_o
);

  localparam int SETTLE_W = $clog2(key_settle_p + 1);

  // Forward S-box; byte b lives at bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_ROUND, S_FINAL, S_DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte i of the block is row i%4, column i/4; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[127-32*col -: 8];
      a1 = s[119-32*col -: 8];
      a2 = s[111-32*col -: 8];
      a3 = s[103-32*col -: 8];
      r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Full AES-256 schedule: 60 words, word 0 at the top of the chain.
  function automatic logic [1919:0] expand_key(input logic [255:0] k);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] chain;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) chain[1919-32*i -: 32] = w[i];
    return chain;
  endfunction

  state_t                fsm_q;
  logic [255:0]          key_q;
  logic [127:0]          state_q;
  logic [3:0]            rnd_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  key_valid_q;

  logic [1919:0]         key_chain;
  logic [127:0]          rk [15];
  logic [127:0]          sr_state;
  logic [127:0]          round_d;
  logic [127:0]          final_d;

  assign key_chain = expand_key(key_q);

  for (genvar gi = 0; gi < 15; gi++) begin : g_rk
    assign rk[gi] = key_chain[1919-128*gi -: 128];
  end

  assign sr_state = shift_rows(sub_bytes(state_q));
  assign round_d  = mix_columns(sr_state) ^ rk[rnd_q];
  assign final_d  = sr_state ^ rk[14];

  assign key_ready_o  = (fsm_q == S_IDLE);
  assign ready_o      = (fsm_q == S_IDLE) & key_valid_q & ~key_v_i;
  assign key_valid_o  = key_valid_q;
  assign v_o          = (fsm_q == S_DONE);
  assign busy_o       = (fsm_q != S_IDLE);
  assign ciphertext_o = state_q;

  // Controller: key capture/settle, round sequencing and output hold.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fsm_q       <= S_IDLE;
      key_q       <= '0;
      state_q     <= '0;
      rnd_q       <= '0;
      settle_q    <= '0;
      key_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (key_v_i) begin
            key_q       <= key_i;
            key_valid_q <= 1'b0;
            settle_q    <= SETTLE_W'(key_settle_p);
            fsm_q       <= S_KEY;
          end else if (v_i && key_valid_q) begin
            state_q <= plaintext_i ^ rk[0];
            rnd_q   <= 4'd1;
            fsm_q   <= S_ROUND;
          end
        end
        S_KEY: begin
          settle_q <= settle_q - SETTLE_W'(1);
          if (settle_q == SETTLE_W'(1)) begin
            key_valid_q <= 1'b1;
            fsm_q       <= S_IDLE;
          end
        end
        S_ROUND: begin
          state_q <= round_d;
          if (rnd_q == 4'd13) begin
            fsm_q <= S_FINAL;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        S_FINAL: begin
          state_q <= final_d;
          fsm_q   <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) fsm_q <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_iter_ctrl.sv
// Bench for aes256_iter_ctrl: known-answer table, multi-cycle corner
// sequences and random blocks checked against a byte-level AES-256 model.
module tb_aes256_iter_ctrl;

  localparam int SETTLE = 2;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk = 1'b0;
  logic         reset_i = 1'b0;
  logic         key_v_i = 1'b0;
  logic [255:0] key_i = '0;
  logic         key_ready_o;
  logic         key_valid_o;
  logic         v_i = 1'b0;
  logic [127:0] plaintext_i = '0;
  logic         ready_o;
  logic         v_o;
  logic [127:0] ciphertext_o;
  logic         ready_i = 1'b0;
  logic         busy_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb [256];

  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  always #5 clk = ~clk;

  aes256_iter_ctrl #(.key_settle_p(SETTLE)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .key_v_i(key_v_i), .key_i(key_i), .key_ready_o(key_ready_o), .key_valid_o(key_valid_o),
    .v_i(v_i), .plaintext_i(plaintext_i), .ready_o(ready_o),
    .v_o(v_o), .ciphertext_o(ciphertext_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  // ---------------- reference model (GF(2^8) arithmetic on byte arrays)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box entry = affine transform of the multiplicative inverse.
  function automatic logic [7:0] sbox_entry(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [7:0]   kb [240];
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [7:0]   t [4];
    logic [7:0]   t0, rc, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 32; i++) kb[i] = key[255-8*i -: 8];
    rc = 8'h01;
    for (int i = 32; i < 240; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = kb[i-4+j];
      if (i % 32 == 0) begin
        t0 = t[0];
        t[0] = sb[t[1]] ^ rc; t[1] = sb[t[2]]; t[2] = sb[t[3]]; t[3] = sb[t0];
        rc = gmul(rc, 8'h02);
      end else if (i % 32 == 16) begin
        for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
      end
      for (int j = 0; j < 4; j++) kb[i+j] = kb[i-32+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ kb[i];
    for (int r = 1; r <= 14; r++) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          sh[row+4*col] = sb[st[row + 4*((col+row)%4)]];
      if (r < 14) begin
        for (int col = 0; col < 4; col++) begin
          a0 = sh[4*col]; a1 = sh[4*col+1]; a2 = sh[4*col+2]; a3 = sh[4*col+3];
          st[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) st[i] = sh[i];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ kb[16*r+i];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = st[i];
    return out;
  endfunction

  // ---------------- checking helpers
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a key in the current IDLE cycle; returns in the first key_valid_o cycle.
  task automatic load_key(input logic [255:0] k, input string tag);
    int lat;
    key_v_i = 1'b1;
    key_i   = k;
    #1;
    chk1({tag, " key_ready_o"}, key_ready_o, 1'b1);
    chk1({tag, " ready_o during key offer"}, ready_o, 1'b0);
    tick();
    key_v_i = 1'b0;
    chk1({tag, " key_valid_o drops"}, key_valid_o, 1'b0);
    lat = 1;
    while (!key_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    chki({tag, " key_valid latency"}, lat, SETTLE + 1);
    $display("%s: key=%h valid after %0d cycles", tag, k, lat);
  endtask

  // Called in cycle 1 after a plaintext accept: checks latency, value,
  // stability over 'hold' stalled cycles, then completes the handshake.
  task automatic wait_ct(input logic [127:0] exp, input string tag, input int hold);
    int lat;
    lat = 1;
    while (!v_o && lat < 40) begin
      tick();
      lat++;
    end
    chki({tag, " latency"}, lat, 15);
    chkw({tag, " ciphertext"}, ciphertext_o, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk1({tag, " v_o held"}, v_o, 1'b1);
      chkw({tag, " ciphertext held"}, ciphertext_o, exp);
      chk1({tag, " ready_o while done"}, ready_o, 1'b0);
    end
    $display("%s: ct=%h latency=%0d stall=%0d", tag, ciphertext_o, lat, hold);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk1({tag, " idle after handshake"}, busy_o, 1'b0);
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [127:0] exp, input string tag, input int hold);
    v_i         = 1'b1;
    plaintext_i = pt;
    #1;
    chk1({tag, " ready_o"}, ready_o, 1'b1);
    tick();
    v_i = 1'b0;
    wait_ct(exp, tag, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [3];
    int           acc_q [$];
    int           vo_q [$];
    logic         seen_v, seen_r;
    logic [255:0] rkey;
    logic [127:0] rpt;
    int           lat;

    for (int x = 0; x < 256; x++) sb[x] = sbox_entry(x[7:0]);

    vecs[0] = '{key: C3_KEY, pt: C3_PT, ct: C3_CT};
    vecs[1] = '{key: C3_KEY, pt: 128'h0, ct: ref_encrypt(C3_KEY, 128'h0)};
    vecs[2] = '{key: 256'h0, pt: 128'h0, ct: Z_CT};

    // Reset and post-reset outputs, with a plaintext already pending.
    reset_i = 1'b0;
    tick();
    tick();
    reset_i     = 1'b1;
    v_i         = 1'b1;
    plaintext_i = C3_PT;
    #1;
    chk1("reset v_o", v_o, 1'b0);
    chk1("reset ready_o", ready_o, 1'b0);
    chk1("reset busy_o", busy_o, 1'b0);
    chk1("reset key_valid_o", key_valid_o, 1'b0);
    chk1("reset key_ready_o", key_ready_o, 1'b1);
    chkw("reset ciphertext_o", ciphertext_o, 128'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1("no key ready_o", ready_o, 1'b0);
    end

    // Pending plaintext must go in on the first key_valid_o cycle.
    load_key(C3_KEY, "pending key");
    chk1("pending accepted", ready_o, 1'b1);
    tick();
    v_i = 1'b0;
    wait_ct(C3_CT, "pending enc", 0);

    // Known-answer table.
    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key, $sformatf("vec%0d key", i));
      encrypt(vecs[i].pt, vecs[i].ct, $sformatf("vec%0d enc", i), 0);
    end

    // Back-pressure under the zero key.
    encrypt(128'h0, Z_CT, "backpressure", 5);

    // Key offer and plaintext offer in the same IDLE cycle.
    load_key(C3_KEY, "c3 reload");
    v_i         = 1'b1;
    plaintext_i = 128'h0;
    chk1("collide busy_o idle", busy_o, 1'b0);
    load_key(256'h0, "collide key");
    chk1("collide plaintext accepted", ready_o, 1'b1);
    tick();
    v_i = 1'b0;
    wait_ct(Z_CT, "collide enc", 0);

    // Reset in cycle 7 of an encryption.
    v_i         = 1'b1;
    plaintext_i = C3_PT;
    tick();
    v_i    = 1'b0;
    seen_v = 1'b0;
    lat    = 1;
    while (lat < 7) begin
      if (v_o) seen_v = 1'b1;
      tick();
      lat++;
    end
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    chk1("midreset v_o", v_o, 1'b0);
    chk1("midreset key_valid_o", key_valid_o, 1'b0);
    chk1("midreset busy_o", busy_o, 1'b0);
    v_i    = 1'b1;
    seen_r = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (v_o) seen_v = 1'b1;
      if (ready_o) seen_r = 1'b1;
      tick();
    end
    chk1("midreset v_o never", seen_v, 1'b0);
    chk1("midreset ready_o blocked", seen_r, 1'b0);
    load_key(C3_KEY, "post-reset key");
    chk1("post-reset accepted", ready_o, 1'b1);
    tick();
    v_i = 1'b0;
    wait_ct(C3_CT, "post-reset enc", 0);

    // Peak throughput: ready_i tied high, plaintext always offered.
    ready_i     = 1'b1;
    v_i         = 1'b1;
    plaintext_i = C3_PT;
    for (int c = 0; c < 48; c++) begin
      #1;
      if (ready_o) acc_q.push_back(c);
      if (v_o) begin
        vo_q.push_back(c);
        chkw("stream ciphertext", ciphertext_o, C3_CT);
      end
      tick();
    end
    v_i     = 1'b0;
    ready_i = 1'b0;
    chki("stream accept count", acc_q.size(), 3);
    chki("stream v_o count", vo_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < acc_q.size()) chki("stream accept cycle", acc_q[k], 16 * k);
      if (k < vo_q.size()) chki("stream v_o cycle", vo_q[k], 16 * k + 15);
    end
    $display("stream: accepts=%p valids=%p", acc_q, vo_q);
    tick();

    // Random keys and blocks against the model, with random stalls.
    for (int n = 0; n < 8; n++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(rkey, $sformatf("rand%0d key", n));
      encrypt(rpt, ref_encrypt(rkey, rpt), $sformatf("rand%0d enc", n), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
